// File: rtl/ysyx_22040759_csr_trap_pkg.sv
// ysyx_22040759_csr_trap_pkg: CSR addresses, cause codes, op encodings and FSM states
package ysyx_22040759_csr_trap_pkg;
    typedef enum logic [1:0] {OP_NONE, OP_W, OP_S, OP_C} csr_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_TRAP, ST_RET, ST_REDIR} state_e;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;
endpackage

// File: rtl/ysyx_22040759_csr_trap_irq_sync.sv
// ysyx_22040759_csr_trap_irq_sync: two-flop synchroniser for asynchronous interrupt lines
module ysyx_22040759_csr_trap_irq_sync #(
    parameter int W = 3
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/ysyx_22040759_csr_trap.sv
// ysyx_22040759_csr_trap: machine-mode CSR file with trap/return sequencer and counters
module ysyx_22040759_csr_trap
    import ysyx_22040759_csr_trap_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h8000_0000)
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_src_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_bad_addr_o,
    input  logic [3:0]      exc_req_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [31:0]     ex_inst_i,
    input  logic            int_ok_i,
    input  logic            instret_inc_i,
    input  logic            irq_sw_i,
    input  logic            irq_tm_i,
    input  logic            irq_ext_i,
    output logic            trap_ack_o,
    output logic            busy_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i
);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    state_e          state_q;
    logic            ms_mie_q, ms_mpie_q, ev_intr_q;
    logic [3:0]      ev_code_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcycle_q, minstret_q;
    logic [XLEN-1:0] ev_pc_q, ev_tval_q, redir_pc_q;
    logic [XLEN-1:0] mstatus_v, mip_v, csr_wdata, trap_base, trap_target;
    logic [2:0]      irq_s, pend;
    logic [3:0]      exc, ev_code;
    logic            hit, idle, irq_take, trap_ev, ret_ev, csr_wr;
    ysyx_22040759_csr_trap_irq_sync #(.W(3)) u_irq_sync (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .d_i      ({irq_ext_i, irq_tm_i, irq_sw_i}),
        .q_o      (irq_s)
    );
    always_comb begin
        mstatus_v = '0;
        mstatus_v[12:11] = 2'b11;
        mstatus_v[7] = ms_mpie_q;
        mstatus_v[3] = ms_mie_q;
        mip_v = '0;
        mip_v[11] = irq_s[2];
        mip_v[7] = irq_s[1];
        mip_v[3] = irq_s[0];
    end
    always_comb begin
        csr_rdata_o = '0;
        hit = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:  csr_rdata_o = mstatus_v;
            CSR_MIE:      csr_rdata_o = mie_q;
            CSR_MTVEC:    csr_rdata_o = mtvec_q;
            CSR_MSCRATCH: csr_rdata_o = mscratch_q;
            CSR_MEPC:     csr_rdata_o = mepc_q;
            CSR_MCAUSE:   csr_rdata_o = mcause_q;
            CSR_MTVAL:    csr_rdata_o = mtval_q;
            CSR_MIP:      csr_rdata_o = mip_v;
            CSR_MCYCLE:   csr_rdata_o = mcycle_q;
            CSR_MINSTRET: csr_rdata_o = minstret_q;
            CSR_MHARTID:  csr_rdata_o = '0;
            default:      hit = 1'b0;
        endcase
    end
    assign csr_bad_addr_o = (csr_op_i != OP_NONE) && !hit;
    assign pend     = {mie_q[11] & irq_s[2], mie_q[7] & irq_s[1], mie_q[3] & irq_s[0]} & {3{ms_mie_q}};
    assign idle     = state_q == ST_IDLE;
    assign irq_take = |pend && int_ok_i;
    assign exc      = csr_valid_i ? exc_req_i : 4'b0;
    assign trap_ev  = irq_take || exc[3] || exc[1] || exc[0];
    assign ret_ev   = exc[2];
    assign trap_ack_o = idle && (trap_ev || ret_ev);
    assign ev_code  = irq_take ? (pend[2] ? CAUSE_MEI : pend[0] ? CAUSE_MSI : CAUSE_MTI) :
                      exc[3] ? CAUSE_ILLEGAL : exc[1] ? CAUSE_BREAK : CAUSE_ECALL;
    assign csr_wdata = csr_op_i == OP_W ? csr_src_i :
                       csr_op_i == OP_S ? csr_rdata_o | csr_src_i : csr_rdata_o & ~csr_src_i;
    // S/C with a zero mask are pure reads and must not disturb side-effecting CSRs
    assign csr_wr = csr_valid_i && csr_op_i != OP_NONE && idle && !trap_ack_o && hit &&
                    (csr_op_i == OP_W || |csr_src_i);
    assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = trap_base +
        ((VECTORED_EN && mtvec_q[1:0] == 2'b01 && ev_intr_q) ? XLEN'({ev_code_q, 2'b00}) : '0);
    assign busy_o           = !idle;
    assign redirect_valid_o = state_q == ST_REDIR;
    assign redirect_pc_o    = redirect_valid_o ? redir_pc_q : '0;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            ms_mie_q   <= 1'b0;
            ms_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            ev_intr_q  <= 1'b0;
            ev_code_q  <= '0;
            ev_pc_q    <= '0;
            ev_tval_q  <= '0;
            redir_pc_q <= '0;
        end else begin
            mcycle_q   <= mcycle_q + XLEN'(1);
            minstret_q <= minstret_q + XLEN'(instret_inc_i);
            if (csr_wr) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        ms_mie_q  <= csr_wdata[3];
                        ms_mpie_q <= csr_wdata[7];
                    end
                    CSR_MIE:      mie_q <= csr_wdata & MIE_MASK;
                    CSR_MTVEC:    mtvec_q <= {csr_wdata[XLEN-1:2], 1'b0, VECTORED_EN & csr_wdata[0]};
                    CSR_MSCRATCH: mscratch_q <= csr_wdata;
                    CSR_MEPC:     mepc_q <= {csr_wdata[XLEN-1:1], 1'b0};
                    CSR_MCAUSE:   mcause_q <= {csr_wdata[XLEN-1], {(XLEN-5){1'b0}}, csr_wdata[3:0]};
                    CSR_MTVAL:    mtval_q <= csr_wdata;
                    CSR_MCYCLE:   mcycle_q <= csr_wdata;
                    CSR_MINSTRET: minstret_q <= csr_wdata;
                    default: ;
                endcase
            end
            case (state_q)
                ST_IDLE: if (trap_ack_o) begin
                    state_q   <= trap_ev ? ST_TRAP : ST_RET;
                    ev_intr_q <= irq_take;
                    ev_code_q <= ev_code;
                    ev_pc_q   <= ex_pc_i;
                    ev_tval_q <= irq_take ? '0 : exc[3] ? XLEN'(ex_inst_i) : exc[1] ? ex_pc_i : '0;
                end
                ST_TRAP: begin
                    mepc_q     <= {ev_pc_q[XLEN-1:1], 1'b0};
                    mcause_q   <= {ev_intr_q, {(XLEN-5){1'b0}}, ev_code_q};
                    mtval_q    <= ev_tval_q;
                    ms_mpie_q  <= ms_mie_q;
                    ms_mie_q   <= 1'b0;
                    redir_pc_q <= trap_target;
                    state_q    <= ST_REDIR;
                end
                ST_RET: begin
                    ms_mie_q   <= ms_mpie_q;
                    ms_mpie_q  <= 1'b1;
                    redir_pc_q <= {mepc_q[XLEN-1:1], 1'b0};
                    state_q    <= ST_REDIR;
                end
                ST_REDIR: if (redirect_ready_i) state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
